input_repeat_debouncer: RTL and testbench
=========================================

// Module: input_repeat_debouncer
// PURPOSE
//   N-channel debouncer with per-channel auto-repeat (DAS/ARR) for the Tetris controls.
//   Turns raw active-low KEY inputs into one-cycle move pulses: one on press, then repeats while held.
//   Sits between the board pins and gamelogic; its pulses drive left_final / right_final / rot_final.
// PARAMETERS
//   N_CH        3           channel count (0=left, 1=right, 2=rotate by convention)
//   DEB_CYC     500000      cycles the synced input must be stable before it is accepted (10 ms @ 50 MHz)
//   DAS_CYC     10000000    delay from press pulse to first repeat pulse (200 ms)
//   ARR_CYC     2500000     period between later repeat pulses (50 ms); must be >= 1
//   ARR_MIN     625000      floor on the repeat period; used only with REPEAT_ACCEL_EN
//   CNT_W       24          counter width; must hold max(DEB_CYC, DAS_CYC, ARR_CYC)
// PORTS
//   CLOCK_50    in   1      system clock, 50 MHz
//   reset       in   1      synchronous, active-high reset
//   key_n       in   N_CH   raw pushbuttons, active low, asynchronous to CLOCK_50
//   rep_en      in   N_CH   per-channel auto-repeat enable (quasi-static; rotate is normally 0)
//   level       out  N_CH   debounced pressed state (1 = held)
//   pulse       out  N_CH   one-cycle move strobe: the press pulse plus any repeat pulses
//   release_p   out  N_CH   one-cycle strobe when the debounced level falls
// BEHAVIOUR
//   Reset: all outputs 0; synchronizers, counters and FSMs go to IDLE with count 0.
//     Reset asserted mid-hold: no pulse in that cycle or the next.
//     After reset releases, a key that is still held must pass full debounce again before it pulses.
//   Sync: 2-FF synchronizer per channel, inverted to active-high (raw_s).
//   Debounce:
//     While raw_s == level, the counter is cleared.
//     Otherwise the counter increments; when it reaches DEB_CYC-1, level toggles on the next edge and the counter clears.
//     Any bounce back before that point clears the counter, so glitches shorter than DEB_CYC never reach level.
//   Latency: raw edge -> level change = 2 + DEB_CYC cycles.
//   pulse on press: asserts in the same cycle that level rises.
//   release_p: asserts in the same cycle that level falls.
//   Repeat FSM, per channel (encoding IDLE=0, DAS=1, RPT=2):
//     IDLE -> DAS on the rising edge of level; emit the press pulse; clear the repeat counter.
//     DAS: the counter counts up. At DAS_CYC-1 it emits a pulse, clears, and goes to RPT.
//       If rep_en == 0 there, it stays in DAS and holds the counter at 0 with no pulses.
//     RPT: emits a pulse every ARR_CYC cycles for as long as level == 1.
//     Any state -> IDLE when level == 0, without emitting a pulse.
//     Release during DAS: no repeat is emitted.
//   Timing from the press pulse at cycle t:
//     repeats at t+DAS_CYC, t+DAS_CYC+ARR_CYC, and so on.
//   Channels are fully independent.
//     Simultaneous presses produce simultaneous pulses; arbitration is gamelogic's job.
//   pulse and release_p are never high together on the same channel.
//   Widths: counters are unsigned CNT_W bits and never wrap; comparisons are made against param-1.
// CONFIGURATION
//   `REPEAT_ACCEL_EN defined:
//     Each channel keeps a cur_arr register, loaded with ARR_CYC on entry to RPT.
//     After every repeat pulse: cur_arr <= max(cur_arr - cur_arr/4, ARR_MIN).
//     Repeat spacing therefore shrinks geometrically to the floor.
//   `REPEAT_ACCEL_EN undefined:
//     Fixed ARR_CYC spacing; the cur_arr register and the ARR_MIN logic are not synthesised.
// STRUCTURE
//   Shared include tetris_input_pkg.vh:
//     FSM state encodings (ST_IDLE, ST_DAS, ST_RPT).
//     Channel index constants (CH_LEFT, CH_RIGHT, CH_ROT).
//     Default timing constants at 50 MHz.
//   Sub-module debounce_channel: single-channel synchronizer, debounce and repeat FSM.
//   input_repeat_debouncer: a generate loop of N_CH debounce_channel instances, plus the output concatenation.
// TESTING (bench params: N_CH=3, DEB_CYC=8, DAS_CYC=20, ARR_CYC=5, ARR_MIN=2)
//   1. Bounce rejection:
//      key_n[0] toggles every 3 cycles for 30 cycles, then settles high.
//      -> level[0] stays 0; no pulse[0].
//   2. Clean press, rep_en=0:
//      key_n[2] held low for 100 cycles.
//      -> level[2] rises 10 cycles after the edge.
//      -> exactly 1 pulse[2] is emitted.
//      -> release_p[2] fires 10 cycles after the key is released.
//   3. Auto-repeat, rep_en[1]=1, key held 60 cycles past the press pulse:
//      -> pulses at t, t+20, t+25, ... t+60, i.e. 10 pulses total (accel off).
//      -> with `REPEAT_ACCEL_EN: inter-pulse gaps 5, 4, 3, 3, 3... clamped at >= 2.
//   4. Release during DAS:
//      press channel 1, release 15 cycles after the press pulse.
//      -> only the press pulse is seen; the FSM returns to IDLE.
//   5. Simultaneous keys:
//      key_n[0] and key_n[1] fall in the same cycle.
//      -> pulse[0] and pulse[1] rise in the same cycle; their repeat trains stay aligned.
//   6. Reset mid-repeat:
//      reset high for 1 cycle while channel 1 is in RPT.
//      -> all outputs are 0 the next cycle.
//      -> key still held: the next pulse[1] comes 2+8 cycles after reset drops.

Source files
------------

// File: rtl/input_repeat_debouncer_pkg.sv
// ============================================================================
// Module : input_repeat_debouncer_pkg
// Brief  : Shared state encodings, channel indices and 50 MHz timing defaults
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package input_repeat_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DAS  = 2'd1,
    ST_RPT  = 2'd2
  } rep_state_e;

  localparam int CH_LEFT  = 0;
  localparam int CH_RIGHT = 1;
  localparam int CH_ROT   = 2;

  // 50 MHz defaults: 10 ms debounce, 200 ms DAS, 50 ms ARR, 12.5 ms ARR floor
  localparam int DEF_N_CH    = 3;
  localparam int DEF_DEB_CYC = 500000;
  localparam int DEF_DAS_CYC = 10000000;
  localparam int DEF_ARR_CYC = 2500000;
  localparam int DEF_ARR_MIN = 625000;
  localparam int DEF_CNT_W   = 24;

endpackage

`default_nettype wire

// File: rtl/input_repeat_debouncer_debounce_channel.sv
// ============================================================================
// Module : input_repeat_debouncer_debounce_channel
// Brief  : One channel: 2-FF sync, debounce and DAS/ARR auto-repeat FSM.
//          Optional macro REPEAT_ACCEL_EN shrinks the repeat period per pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module input_repeat_debouncer_debounce_channel
  import input_repeat_debouncer_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC,
  parameter int DAS_CYC = DEF_DAS_CYC,
  parameter int ARR_CYC = DEF_ARR_CYC,
`ifdef REPEAT_ACCEL_EN
  parameter int ARR_MIN = DEF_ARR_MIN,
`endif
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  input  logic rep_en_i,
  output logic level_o,
  output logic pulse_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             pulse_q, release_q;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] rpt_cnt_q;
  logic [CNT_W-1:0] arr_last;
  rep_state_e       state_q;

  // Synchronizer captures the inverted key, so raw_s is active-high
  logic raw_s;
  assign raw_s = sync2_q;

  always_comb begin
    level_d   = level_q;
    deb_cnt_d = '0;
    if (raw_s != level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        level_d = ~level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      deb_cnt_q <= '0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= ~key_n_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      deb_cnt_q <= deb_cnt_d;
      release_q <= level_q & ~level_d;
    end
  end

`ifdef REPEAT_ACCEL_EN
  localparam logic [CNT_W-1:0] ARR_INIT  = CNT_W'(ARR_CYC);
  localparam logic [CNT_W-1:0] ARR_FLOOR = CNT_W'(ARR_MIN);

  logic [CNT_W-1:0] cur_arr_q;
  logic [CNT_W-1:0] arr_shrunk;
  logic [CNT_W-1:0] arr_next;

  assign arr_shrunk = cur_arr_q - (cur_arr_q >> 2);
  assign arr_next   = (arr_shrunk < ARR_FLOOR) ? ARR_FLOOR : arr_shrunk;
  assign arr_last   = cur_arr_q - ONE;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_arr_q <= ARR_INIT;
    end else if (state_q == ST_DAS && level_d && rep_en_i && rpt_cnt_q == DAS_LAST) begin
      cur_arr_q <= ARR_INIT;
    end else if (state_q == ST_RPT && level_d && rpt_cnt_q == arr_last) begin
      cur_arr_q <= arr_next;
    end
  end
`else
  assign arr_last = CNT_W'(ARR_CYC - 1);
`endif

  // FSM steers on level_d so a repeat can never coincide with the release strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      rpt_cnt_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rpt_cnt_q <= '0;
          if (level_d) begin
            state_q <= ST_DAS;
            pulse_q <= 1'b1;
          end
        end
        ST_DAS: begin
          if (!level_d) begin
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
          end else if (!rep_en_i) begin
            rpt_cnt_q <= '0;
          end else if (rpt_cnt_q == DAS_LAST) begin
            state_q   <= ST_RPT;
            rpt_cnt_q <= '0;
            pulse_q   <= 1'b1;
          end else begin
            rpt_cnt_q <= rpt_cnt_q + ONE;
          end
        end
        ST_RPT: begin
          if (!level_d) begin
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
          end else if (rpt_cnt_q == arr_last) begin
            rpt_cnt_q <= '0;
            pulse_q   <= 1'b1;
          end else begin
            rpt_cnt_q <= rpt_cnt_q + ONE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          rpt_cnt_q <= '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign pulse_o   = pulse_q;
  assign release_o = release_q;

endmodule

`default_nettype wire

// File: rtl/input_repeat_debouncer.sv
// ============================================================================
// Module : input_repeat_debouncer
// Brief  : N-channel key debouncer with per-channel DAS/ARR auto-repeat.
//          Macro REPEAT_ACCEL_EN enables geometric repeat acceleration.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module input_repeat_debouncer
  import input_repeat_debouncer_pkg::*;
#(
`ifdef REPEAT_ACCEL_EN
  parameter int ARR_MIN = DEF_ARR_MIN,
`endif
  parameter int N_CH    = DEF_N_CH,
  parameter int DEB_CYC = DEF_DEB_CYC,
  parameter int DAS_CYC = DEF_DAS_CYC,
  parameter int ARR_CYC = DEF_ARR_CYC,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic [N_CH-1:0] key_n,
  input  logic [N_CH-1:0] rep_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] pulse,
  output logic [N_CH-1:0] release_p
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    input_repeat_debouncer_debounce_channel #(
`ifdef REPEAT_ACCEL_EN
      .ARR_MIN (ARR_MIN),
`endif
      .DEB_CYC (DEB_CYC),
      .DAS_CYC (DAS_CYC),
      .ARR_CYC (ARR_CYC),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk_i     (CLOCK_50),
      .rst_i     (reset),
      .key_n_i   (key_n[g]),
      .rep_en_i  (rep_en[g]),
      .level_o   (level[g]),
      .pulse_o   (pulse[g]),
      .release_o (release_p[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_input_repeat_debouncer.sv
// ============================================================================
// Module : tb_input_repeat_debouncer
// Brief  : Scoreboard bench; expected pulse/release cycles queued at stimulus.
//          Honours REPEAT_ACCEL_EN for the repeat-gap model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_input_repeat_debouncer;
  import input_repeat_debouncer_pkg::*;

  localparam int NCH = 3;
  localparam int DEB = 8;
  localparam int DAS = 20;
  localparam int ARR = 5;
`ifdef REPEAT_ACCEL_EN
  localparam int AMIN = 2;
`endif
  localparam int LAT = 2 + DEB;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] key_n;
  logic [NCH-1:0] rep_en;
  logic [NCH-1:0] level;
  logic [NCH-1:0] pulse;
  logic [NCH-1:0] release_p;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int exp_pulse [NCH][$];
  int exp_rel   [NCH][$];

  input_repeat_debouncer #(
`ifdef REPEAT_ACCEL_EN
    .ARR_MIN (AMIN),
`endif
    .N_CH    (NCH),
    .DEB_CYC (DEB),
    .DAS_CYC (DAS),
    .ARR_CYC (ARR),
    .CNT_W   (8)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .key_n     (key_n),
    .rep_en    (rep_en),
    .level     (level),
    .pulse     (pulse),
    .release_p (release_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press pulse at p, level falls at l; repeats only while level is still high
  task automatic push_train(input int ch, input int p, input int l, input bit rep, input bit rel);
    int t;
    int gap;
    exp_pulse[ch].push_back(p);
    if (rep && (p + DAS < l)) begin
      exp_pulse[ch].push_back(p + DAS);
      gap = ARR;
      t   = p + DAS + ARR;
      while (t < l) begin
        exp_pulse[ch].push_back(t);
`ifdef REPEAT_ACCEL_EN
        gap = gap - gap / 4;
        if (gap < AMIN) gap = AMIN;
`endif
        t = t + gap;
      end
    end
    if (rel) exp_rel[ch].push_back(l);
  endtask

  always @(negedge clk) begin : mon
    logic ep;
    logic er;
    for (int ch = 0; ch < NCH; ch++) begin
      ep = (exp_pulse[ch].size() > 0) && (exp_pulse[ch][0] == cyc);
      if (ep) void'(exp_pulse[ch].pop_front());
      if (pulse[ch] || ep)
        check($sformatf("pulse%0d@%0d", ch, cyc), int'(pulse[ch]), int'(ep));
      er = (exp_rel[ch].size() > 0) && (exp_rel[ch][0] == cyc);
      if (er) void'(exp_rel[ch].pop_front());
      if (release_p[ch] || er)
        check($sformatf("release%0d@%0d", ch, cyc), int'(release_p[ch]), int'(er));
    end
  end

  initial begin : stim
    int c0;
    int p;
    int r;

    reset  = 1'b1;
    key_n  = '1;
    rep_en = '0;
    tick(3);
    check("rst_level", int'(level), 0);
    check("rst_pulse", int'(pulse), 0);
    check("rst_release", int'(release_p), 0);
    reset = 1'b0;
    tick(5);

    // Bounce shorter than the debounce window never reaches level
    for (int i = 0; i < 10; i++) begin
      key_n[CH_LEFT] = ~key_n[CH_LEFT];
      tick(3);
      check("bounce_level", int'(level[CH_LEFT]), 0);
    end
    key_n[CH_LEFT] = 1'b1;
    tick(20);
    check("bounce_settled", int'(level[CH_LEFT]), 0);

    // Clean press on rotate, no repeat
    rep_en = '0;
    key_n[CH_ROT] = 1'b0;
    c0 = cyc;
    push_train(CH_ROT, c0 + LAT, c0 + 100 + LAT, 1'b0, 1'b1);
    tick(LAT - 1);
    check("rot_level_pre", int'(level[CH_ROT]), 0);
    tick(1);
    check("rot_level_rise", int'(level[CH_ROT]), 1);
    tick(100 - LAT);
    key_n[CH_ROT] = 1'b1;
    tick(LAT - 1);
    check("rot_level_held", int'(level[CH_ROT]), 1);
    tick(1);
    check("rot_level_fall", int'(level[CH_ROT]), 0);
    tick(20);

    // Auto-repeat on right, held through t+60
    rep_en[CH_RIGHT] = 1'b1;
    key_n[CH_RIGHT]  = 1'b0;
    c0 = cyc;
    p  = c0 + LAT;
    push_train(CH_RIGHT, p, p + 55 + LAT, 1'b1, 1'b1);
    tick(LAT + 55);
    key_n[CH_RIGHT] = 1'b1;
    tick(40);
    check("rpt_drained", exp_pulse[CH_RIGHT].size(), 0);

    // Level falls 15 cycles after the press pulse, inside DAS
    key_n[CH_RIGHT] = 1'b0;
    c0 = cyc;
    p  = c0 + LAT;
    push_train(CH_RIGHT, p, p + 15, 1'b1, 1'b1);
    tick(LAT + 5);
    key_n[CH_RIGHT] = 1'b1;
    tick(40);
    check("das_rel_level", int'(level[CH_RIGHT]), 0);

    // Simultaneous presses with repeat on both
    rep_en = 3'b011;
    key_n[CH_LEFT]  = 1'b0;
    key_n[CH_RIGHT] = 1'b0;
    c0 = cyc;
    p  = c0 + LAT;
    push_train(CH_LEFT,  p, p + 45 + LAT, 1'b1, 1'b1);
    push_train(CH_RIGHT, p, p + 45 + LAT, 1'b1, 1'b1);
    tick(LAT + 45);
    key_n[CH_LEFT]  = 1'b1;
    key_n[CH_RIGHT] = 1'b1;
    tick(40);

    // Reset while right is in RPT, key still held afterwards
    rep_en = 3'b010;
    key_n[CH_RIGHT] = 1'b0;
    c0 = cyc;
    p  = c0 + LAT;
    r  = p + 28;
    push_train(CH_RIGHT, p, r, 1'b1, 1'b0);
    tick(r - 1 - c0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst_mid_level", int'(level), 0);
    check("rst_mid_pulse", int'(pulse), 0);
    check("rst_mid_release", int'(release_p), 0);
    push_train(CH_RIGHT, r + LAT, r + 40 + LAT, 1'b1, 1'b1);
    tick(40);
    key_n[CH_RIGHT] = 1'b1;
    tick(40);

    for (int ch = 0; ch < NCH; ch++) begin
      check($sformatf("pulse_left%0d", ch), exp_pulse[ch].size(), 0);
      check($sformatf("release_left%0d", ch), exp_rel[ch].size(), 0);
    end
    check("final_level", int'(level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
